// File: rtl/alu_issue_decode.sv
// alu_issue_decode: RV32 ALU decode/issue stage with a 2-entry skid buffer and a saturating illegal-instruction counter.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   in_valid/in_ready                upstream handshake (in_ready registered, equals NOT skid_full)
//   in_instr, in_rs1_data, in_rs2_data  instruction word and operands
//   out_valid/out_ready              execute-stage handshake
//   A, B, ALU_control, out_rd        decoded ALU operation
//   out_illegal                      issued instruction is unsupported (operands/opcode forced to 0)
//   illegal_count                    saturating count of illegal instructions transferred out
// Config: define ALU_ISSUE_IMM_EN to decode I-type ALU instructions (opcode 0010011); otherwise they are illegal.
module alu_issue_decode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      A,
  output logic [31:0]      B,
  output logic [2:0]       ALU_control,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);
  typedef struct packed {
    logic        illegal;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;
  op_t dec, out_q, out_d, skid_q, skid_d;
  logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic acc, drain;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic unused_ok;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign unused_ok = ^in_instr[24:15];
  assign acc = in_valid && in_ready_q;
  assign drain = out_valid_q && out_ready;
  // funct3 to ALU opcode for the add/and/or/slt/xor/sll/srl family shared by R- and I-type
  function automatic logic [2:0] alu_of(input logic [2:0] f);
    case (f)
      3'b111:  alu_of = 3'b010;
      3'b110:  alu_of = 3'b011;
      3'b010:  alu_of = 3'b100;
      3'b100:  alu_of = 3'b101;
      3'b001:  alu_of = 3'b110;
      3'b101:  alu_of = 3'b111;
      default: alu_of = 3'b000;
    endcase
  endfunction
  always_comb begin
    dec = '{illegal: 1'b1, ctl: 3'd0, rd: in_instr[11:7], a: 32'd0, b: 32'd0};
    if (opc == 7'b0110011 && ((f7 == 7'd0 && f3 != 3'b011) || (f7 == 7'b0100000 && f3 == 3'b000))) begin
      dec.illegal = 1'b0;
      dec.ctl = f7[5] ? 3'b001 : alu_of(f3);
      dec.a = in_rs1_data;
      dec.b = in_rs2_data;
    end
`ifdef ALU_ISSUE_IMM_EN
    // shifts (funct3 x01) need a zero upper field; sltiu (011) is unsupported
    if (opc == 7'b0010011 && ((f3[1:0] == 2'b01) ? (f7 == 7'd0) : (f3 != 3'b011))) begin
      dec.illegal = 1'b0;
      dec.ctl = alu_of(f3);
      dec.a = in_rs1_data;
      dec.b = (f3[1:0] == 2'b01) ? {27'd0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
    end
`endif
  end
  // skid holds data only while the output register is stalled; when the output
  // register frees up, skid (older) takes priority, and in_ready guarantees no
  // accept can coincide with a full skid
  always_comb begin
    out_d = out_q;
    out_valid_d = out_valid_q;
    skid_d = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d = (drain && out_q.illegal && ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
    if (!out_valid_q || drain) begin
      out_valid_d = skid_valid_q || acc;
      out_d = skid_valid_q ? skid_q : acc ? dec : out_q;
      skid_valid_d = 1'b0;
    end else if (acc) begin
      skid_d = dec;
      skid_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      skid_q <= '0;
      out_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_valid_q <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q <= ~skid_valid_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign A = out_q.a;
  assign B = out_q.b;
  assign ALU_control = out_q.ctl;
  assign out_rd = out_q.rd;
  assign out_illegal = out_q.illegal;
  assign illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_decode.sv
// tb_alu_issue_decode: scoreboard bench for alu_issue_decode.
module tb_alu_issue_decode;
  localparam int CW = 3;
  localparam logic [2:0] TBL [8] = '{3'd0, 3'd6, 3'd4, 3'd0, 3'd5, 3'd7, 3'd3, 3'd2};
  localparam logic [31:0] INS [14] = '{
    32'h002081B3, 32'h402081B3, 32'h0020F1B3, 32'h0020E1B3, 32'h0020A1B3,
    32'h0020C1B3, 32'h002091B3, 32'h0020D1B3, 32'h0020B1B3, 32'h4020D1B3,
    32'h022081B3, 32'hFFF08193, 32'h00309193, 32'h40309193};
  typedef struct packed {
    logic        ill;
    logic [2:0]  ctl;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } res_t;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_illegal;
  logic [31:0] in_instr = '0, in_rs1_data = '0, in_rs2_data = '0, A, B;
  logic [2:0] ALU_control;
  logic [4:0] out_rd;
  logic [CW-1:0] illegal_count;
  res_t q[$];
  res_t prev;
  logic prev_stall = 1'b0;
  logic a_;
  int checks = 0, failures = 0, cnt_m = 0;
  alu_issue_decode #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .out_valid(out_valid),
    .out_ready(out_ready), .A(A), .B(B), .ALU_control(ALU_control), .out_rd(out_rd),
    .out_illegal(out_illegal), .illegal_count(illegal_count));
  always #5 clk = ~clk;
  function automatic res_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
    res_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    r = '{ill: 1'b1, ctl: 3'd0, rd: ins[11:7], a: 32'd0, b: 32'd0};
    if (ins[6:0] == 7'h33) begin
      if (f7 == 7'h00 && f3 != 3'd3) r = '{ill: 1'b0, ctl: TBL[f3], rd: ins[11:7], a: r1, b: r2};
      else if (f7 == 7'h20 && f3 == 3'd0) r = '{ill: 1'b0, ctl: 3'd1, rd: ins[11:7], a: r1, b: r2};
    end
`ifdef ALU_ISSUE_IMM_EN
    if (ins[6:0] == 7'h13) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        if (f7 == 7'h00) r = '{ill: 1'b0, ctl: TBL[f3], rd: ins[11:7], a: r1, b: {27'd0, ins[24:20]}};
      end else if (f3 != 3'd3) r = '{ill: 1'b0, ctl: TBL[f3], rd: ins[11:7], a: r1, b: {{20{ins[31]}}, ins[31:20]}};
    end
`endif
    return r;
  endfunction
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic sample(output logic accepted);
    res_t got, e;
    @(negedge clk);
    got = '{ill: out_illegal, ctl: ALU_control, rd: out_rd, a: A, b: B};
    chk("illegal_count", 80'(illegal_count), 80'(cnt_m));
    if (prev_stall) chk("hold", 80'(got), 80'(prev));
    if (out_valid && out_ready) begin
      checks++;
      assert (q.size() > 0) else begin
        failures++;
        $error("FAIL spurious_output got=%h exp=none", got);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data", 80'(got), 80'(e));
        if (e.ill && cnt_m < (2 ** CW) - 1) cnt_m++;
      end
    end
    accepted = in_valid && in_ready;
    if (accepted) q.push_back(model(in_instr, in_rs1_data, in_rs2_data));
    prev_stall = out_valid && !out_ready;
    prev = got;
  endtask
  task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, output logic accepted);
    in_valid = v;
    in_instr = ins;
    in_rs1_data = $urandom;
    in_rs2_data = $urandom;
    out_ready = ordy;
    sample(accepted);
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] ins, input logic ordy);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) cyc(1'b1, ins, ordy, ok);
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL accept_timeout got=0 exp=1");
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) cyc(1'b0, 32'd0, 1'b1, a_);
    cyc(1'b0, 32'd0, 1'b1, a_);
    chk("drained", 80'(q.size()), 80'd0);
  endtask
  initial begin
    @(negedge clk);
    chk("rst_out_valid", 80'(out_valid), 80'd0);
    chk("rst_in_ready", 80'(in_ready), 80'd0);
    chk("rst_fields", {A, B, ALU_control, out_rd, out_illegal}, 80'd0);
    chk("rst_cnt", 80'(illegal_count), 80'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_before_edge", 80'(in_ready), 80'd0);
    @(posedge clk);
    #1;
    chk("in_ready_rises", 80'(in_ready), 80'd1);
    cyc(1'b1, 32'h002081B3, 1'b1, a_);
    chk("latency", 80'(out_valid), 80'd1);
    chk("add_fields", {A == in_rs1_data, B == in_rs2_data, ALU_control, out_rd}, {1'b1, 1'b1, 3'd0, 5'd3});
    for (int i = 0; i < 14; i++) cyc(1'b1, INS[i], 1'b1, a_);
    drain();
    // four back-to-back with a 2-cycle output stall
    cyc(1'b1, INS[2], 1'b0, a_);
    cyc(1'b1, INS[3], 1'b0, a_);
    chk("in_ready_drop", 80'(in_ready), 80'd0);
    push(INS[4], 1'b1);
    push(INS[5], 1'b1);
    drain();
    // saturation: nine illegals into a 3-bit counter
    for (int i = 0; i < 9; i++) push(32'h0020B1B3, 1'b1);
    drain();
    chk("cnt_saturated", 80'(illegal_count), 80'd7);
    // random handshake mix
    for (int i = 0; i < 60; i++) cyc(1'($urandom_range(1)), INS[$urandom_range(13)], 1'($urandom_range(1)), a_);
    drain();
    // fill output and skid, then reset between edges
    cyc(1'b1, 32'h0020B1B3, 1'b0, a_);
    cyc(1'b1, 32'h022081B3, 1'b0, a_);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 80'(out_valid), 80'd0);
    chk("async_cnt", 80'(illegal_count), 80'd0);
    chk("async_in_ready", 80'(in_ready), 80'd0);
    q.delete();
    cnt_m = 0;
    prev_stall = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    push(32'h402081B3, 1'b1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_decode.md
ALU_ISSUE_DECODE -- requirements
Module: alu_issue_decode

Interface
- REQ-001: Parameter CNT_W, default 16, sets the width of the illegal-instruction counter.
- REQ-002: clk  input  1  the single clock; every register updates on its rising edge.
- REQ-003: rst  input  1  asynchronous, active-high reset.
- REQ-004: in_valid  input  1  the upstream stage presents an instruction and operands.
- REQ-005: in_ready  output  1  the block accepts the input this cycle.
- REQ-006: in_instr  input  32  RV32 instruction word.
- REQ-007: in_rs1_data  input  32  rs1 operand value.
- REQ-008: in_rs2_data  input  32  rs2 operand value.
- REQ-009: out_valid  output  1  the issued ALU operation is valid.
- REQ-010: out_ready  input  1  the execute stage consumes the output this cycle.
- REQ-011: A  output  32  ALU operand A.
- REQ-012: B  output  32  ALU operand B.
- REQ-013: ALU_control  output  3  ALU opcode: 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor, 110 sll, 111 srl.
- REQ-014: out_rd  output  5  destination register, taken from instr[11:7].
- REQ-015: out_illegal  output  1  the issued instruction is unsupported.
- REQ-016: illegal_count  output  CNT_W  saturating count of illegal instructions issued.

Function
- REQ-017: A transfer SHALL occur on a cycle where in_valid and in_ready are both 1 (input side), or out_valid and out_ready are both 1 (output side).
- REQ-018: Latency SHALL be exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
- REQ-019: Throughput SHALL be one instruction per cycle while out_ready=1.
- REQ-020: Opcode 0110011 (R-type), with funct7=0000000, SHALL map funct3 000/111/110/010/100/001/101 to add/and/or/slt/xor/sll/srl; A=rs1, B=rs2.
- REQ-021: R-type with funct7=0100000 and funct3=000 SHALL map to sub.
- REQ-022: All other funct3/funct7 combinations (sltu, sra, mul, etc.) SHALL be illegal.
- REQ-023: Any opcode other than those enabled SHALL be illegal.
- REQ-024: An illegal instruction SHALL still issue, with out_illegal=1, ALU_control=000, A=0, B=0, and out_rd passed through.
- REQ-025: Output storage SHALL be a 2-entry skid buffer (output register plus skid register).
- REQ-026: in_ready SHALL be registered and equal to NOT skid_full.
- REQ-027: When the output register is full and out_ready=0, an accepted input SHALL go to the skid register.
- REQ-028: When the output register drains, skid contents SHALL move to the output register in that same cycle.
- REQ-029: Outputs A, B, ALU_control, out_rd and out_illegal SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-030: Data SHALL never be dropped or duplicated, including when an input accept and an output drain happen in the same cycle.
- REQ-031: illegal_count SHALL increment by 1 on each output transfer with out_illegal=1.
- REQ-032: illegal_count SHALL saturate at all-ones and not wrap.

Reset
- REQ-033: On rst=1 (asynchronous): out_valid=0, in_ready=0, skid empty, A=0, B=0, ALU_control=000, out_rd=0, out_illegal=0, illegal_count=0.
- REQ-034: in_ready SHALL rise on the first clk edge after rst deasserts.
- REQ-035: Reset mid-transfer SHALL discard all buffered entries.

Configuration
- REQ-036: Macro ALU_ISSUE_IMM_EN SHALL control I-type support.
- REQ-037: With ALU_ISSUE_IMM_EN defined, opcode 0010011 SHALL decode funct3 000/111/110/010/100 as add/and/or/slt/xor, with B = sign-extended instr[31:20].
- REQ-038: With ALU_ISSUE_IMM_EN defined, funct3 001/101 with instr[31:25]=0 SHALL decode as sll/srl with B = zero-extended instr[24:20]; any other instr[31:25] value for those funct3 SHALL be illegal.
- REQ-039: Without ALU_ISSUE_IMM_EN, opcode 0010011 SHALL be illegal.

Verification
- REQ-040: in_instr=0x002081B3, rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, ALU_control=000, A=5, B=7, out_rd=3.
- REQ-041: in_instr=0x402081B3 -> ALU_control=001.
- REQ-042: in_instr=0x0020B1B3 (sltu) -> out_illegal=1, A=0, B=0, illegal_count 0->1.
- REQ-043: With ALU_ISSUE_IMM_EN defined, in_instr=0xFFF08193 -> ALU_control=000, B=0xFFFFFFFF; without the macro -> out_illegal=1.
- REQ-044: Stream 4 back-to-back instructions while out_ready=0 for 2 cycles -> in_ready drops after 2 accepts; all 4 emerge in order, with no loss or duplication.
- REQ-045: Assert rst while skid is full -> out_valid=0 and illegal_count=0 immediately, without waiting for a clk edge.
